mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style FSM that sequences a shared-ALU, shared-memory multi-cycle MIPS datapath through fetch, decode, execute, memory and writeback steps.
- Sits beside the datapath. It takes opcode from the instruction register and a ready handshake from unified memory, and drives every datapath enable and mux select.
- Supports R-type, addi, lw, sw, beq and j. Any other opcode raises an illegal-instruction pulse and skips the instruction.

Parameters:
- CNT_WIDTH, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag, for beq.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load qualified by zero (the datapath ANDs it).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- memtoreg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- regdest  out  1  destination register select: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- aluop  out  2  00 = add, 01 = sub, 10 = decode funct.
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- State register reset (asynchronous): rst forces state IDLE, in which all outputs are 0.
  - IDLE -> FETCH unconditionally on the first clk after rst deasserts.
  - Reset mid-operation aborts immediately; outputs drop to 0 combinationally.
- Outputs are combinational functions of state, plus mem_ready gating where noted. Every output not listed for a state is 0.
- FETCH:
  - Drives memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite equal mem_ready.
  - Stays in FETCH while mem_ready=0 with requests held stable; -> DECODE on mem_ready=1.
- DECODE:
  - Drives alusrca=0, alusrcb=11, aluop=00 (computes the branch target).
  - Next state by opcode:
    - 000000 -> EXEC.
    - 001000 -> ADDI_EXEC.
    - 100011 or 101011 -> MEMADR.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - Any other opcode: illegal=1 for this cycle, -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: memread=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0. -> FETCH.
- MEMWRITE: memwrite=1, iord=1. Waits for mem_ready, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
- ALUWB: regwrite=1, regdest=1, memtoreg=0. -> FETCH.
- ADDI_EXEC: alusrca=1, alusrcb=10, aluop=00. -> ADDI_WB.
- ADDI_WB: regwrite=1, regdest=0, memtoreg=0. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. -> FETCH.
- JUMP: pcwrite=1, pcsource=10. -> FETCH.
- Latency with mem_ready constantly 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
  - Each cycle of mem_ready=0 in a memory state adds one cycle.
- Handshake: memread/memwrite, once raised, stay high until the cycle in which mem_ready=1. mem_ready outside a memory state is ignored.
- opcode is sampled only in DECODE and MEMADR; the datapath holds the instruction register stable otherwise.
- Unreachable state encodings -> FETCH.

Optional Feature:
- MIPS_CTRL_PERF_EN defined: adds two outputs, cycle_cnt[CNT_WIDTH] and instret_cnt[CNT_WIDTH].
  - Both reset asynchronously to 0.
  - cycle_cnt increments every cycle in any state other than IDLE.
  - instret_cnt increments on each transition into FETCH from a terminal state: MEMWB, MEMWRITE, ALUWB, ADDI_WB, BRANCH or JUMP. Illegal opcodes are not counted.
  - Both counters wrap modulo 2^CNT_WIDTH.
- Undefined: the ports and logic are absent; the FSM is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - Opcode localparams: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - The ctrl_state_t enum.
  - Encodings for aluop, alusrcb and pcsource.
- No sub-module in the base block. The perf counters may be a small mips_perf_cnt sub-module instantiated under the macro.

Test Plan:
- Reset/idle: rst high for 3 cycles, then low with mem_ready=1 -> IDLE cycle with all outputs 0, then FETCH with memread=1, irwrite=1, pcwrite=1.
- lw with mem_ready=1: opcode=100011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5 only.
- Memory stall: sw with mem_ready=0 for 3 cycles in MEMWRITE -> memwrite stays high 4 cycles, iord=1 throughout, no state advance until mem_ready=1.
- R-type then beq: opcode=000000 gives aluop=10 in EXEC, regdest=1 and regwrite=1 in ALUWB. opcode=000100 gives aluop=01 and pcwritecond=1 in BRANCH for both zero=0 and zero=1.
- Illegal opcode: opcode=111111 in DECODE -> illegal=1 for exactly one cycle, next state FETCH, no regwrite or memwrite asserted.
- Reset mid-MEMREAD: rst asserted asynchronously -> memread drops before the next clk edge, and state is IDLE after rst deasserts.
- With MIPS_CTRL_PERF_EN: run 2 addi and 1 j with mem_ready=1 from FETCH -> instret_cnt=3 and cycle_cnt=11 at the return to FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM states
// and the encodings of the ALU, ALU-B and PC-source selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXEC      = 4'd7,
    S_ALUWB     = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing a shared-ALU/shared-memory multi-cycle MIPS datapath.
// Define MIPS_CTRL_PERF_EN to add cycle and retired-instruction counters.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
`endif
);

  ctrl_state_t state_q, state_d;

  // zero is qualified in the datapath via pcwritecond
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdest  = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef MIPS_CTRL_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;
  logic                 retire;

  // An instruction retires when a terminal state hands back to FETCH;
  // illegal opcodes leave from DECODE and so are never counted.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_IDLE) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    if (retire)            instret_cnt_d = instret_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  localparam int unused_cnt_w = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues the expected
// output word per cycle, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdest, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsource;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mips_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Word layout: {pcwrite pcwritecond iord memread memwrite irwrite memtoreg
  // regdest regwrite alusrca}_{alusrcb}_{aluop}_{pcsource}_{illegal}
  logic [16:0] act;
  assign act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdest, regwrite, alusrca, alusrcb, aluop, pcsource, illegal};

  localparam logic [16:0] E_ZERO      = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] E_FETCH     = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] E_FETCH_WT  = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] E_DECODE    = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] E_DEC_ILL   = 17'b0000000000_11_00_00_1;
  localparam logic [16:0] E_MEMADR    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] E_MEMREAD   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] E_MEMWB     = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] E_MEMWRITE  = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] E_EXEC      = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] E_ALUWB     = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] E_ADDI_EXEC = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] E_ADDI_WB   = 17'b0000000010_00_00_00_0;
  localparam logic [16:0] E_BRANCH    = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] E_JUMP      = 17'b1000000000_00_00_10_0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_AI  = 6'b001000;
  localparam logic [5:0] OP_L   = 6'b100011;
  localparam logic [5:0] OP_S   = 6'b101011;
  localparam logic [5:0] OP_B   = 6'b000100;
  localparam logic [5:0] OP_JMP = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [16:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check(mon_e.name, {15'd0, act}, {15'd0, mon_e.vec});
    end
  end

  // Drive one cycle of inputs from posedge+1 and queue its expected outputs.
  task automatic step(input string nm, input logic [5:0] op, input logic r,
                      input logic z, input logic [16:0] e);
    exp_t x;
    opcode    = op;
    mem_ready = r;
    zero      = z;
    x.name    = nm;
    x.vec     = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("reset", OP_R, 1'b1, 1'b0, E_ZERO);
    rst = 1'b0;
    step("idle", OP_L, 1'b1, 1'b0, E_ZERO);

    // lw, no stalls: 5 cycles
    step("lw fetch",   OP_L, 1'b1, 1'b0, E_FETCH);
    step("lw decode",  OP_L, 1'b1, 1'b0, E_DECODE);
    step("lw memadr",  OP_L, 1'b1, 1'b0, E_MEMADR);
    step("lw memread", OP_L, 1'b1, 1'b0, E_MEMREAD);
    step("lw memwb",   OP_L, 1'b1, 1'b0, E_MEMWB);

    // sw with one fetch stall and three write stalls
    step("sw fetch wait", OP_S, 1'b0, 1'b0, E_FETCH_WT);
    step("sw fetch",      OP_S, 1'b1, 1'b0, E_FETCH);
    step("sw decode",     OP_S, 1'b0, 1'b0, E_DECODE);
    step("sw memadr",     OP_S, 1'b0, 1'b0, E_MEMADR);
    for (int i = 0; i < 3; i++) step("sw memwrite stall", OP_S, 1'b0, 1'b0, E_MEMWRITE);
    step("sw memwrite done", OP_S, 1'b1, 1'b0, E_MEMWRITE);

    // R-type
    step("r fetch",  OP_R, 1'b1, 1'b0, E_FETCH);
    step("r decode", OP_R, 1'b1, 1'b0, E_DECODE);
    step("r exec",   OP_R, 1'b1, 1'b0, E_EXEC);
    step("r aluwb",  OP_R, 1'b1, 1'b0, E_ALUWB);

    // beq with zero=0 then zero=1
    step("beq0 fetch",  OP_B, 1'b1, 1'b0, E_FETCH);
    step("beq0 decode", OP_B, 1'b1, 1'b0, E_DECODE);
    step("beq0 branch", OP_B, 1'b1, 1'b0, E_BRANCH);
    step("beq1 fetch",  OP_B, 1'b1, 1'b1, E_FETCH);
    step("beq1 decode", OP_B, 1'b1, 1'b1, E_DECODE);
    step("beq1 branch", OP_B, 1'b1, 1'b1, E_BRANCH);

    // illegal opcode: one-cycle pulse, straight back to FETCH
    step("ill fetch",  OP_BAD, 1'b1, 1'b0, E_FETCH);
    step("ill decode", OP_BAD, 1'b1, 1'b0, E_DEC_ILL);

    // addi then j
    step("addi fetch", OP_AI, 1'b1, 1'b0, E_FETCH);
    step("addi decode", OP_AI, 1'b1, 1'b0, E_DECODE);
    step("addi exec",   OP_AI, 1'b1, 1'b0, E_ADDI_EXEC);
    step("addi wb",     OP_AI, 1'b1, 1'b0, E_ADDI_WB);
    step("j fetch",  OP_JMP, 1'b1, 1'b0, E_FETCH);
    step("j decode", OP_JMP, 1'b1, 1'b0, E_DECODE);
    step("j jump",   OP_JMP, 1'b1, 1'b0, E_JUMP);

    // lw interrupted by an asynchronous reset during MEMREAD
    step("lw2 fetch",  OP_L, 1'b1, 1'b0, E_FETCH);
    step("lw2 decode", OP_L, 1'b1, 1'b0, E_DECODE);
    step("lw2 memadr", OP_L, 1'b1, 1'b0, E_MEMADR);
    begin
      exp_t x;
      mem_ready = 1'b0;
      x.name = "lw2 memread";
      x.vec  = E_MEMREAD;
      sb.push_back(x);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async rst memread", {31'd0, memread}, 32'd0);
    check("async rst outputs", {15'd0, act}, 32'd0);
    @(posedge clk);
    #1;
    step("rst held", OP_L, 1'b1, 1'b0, E_ZERO);
    rst = 1'b0;
    step("idle after rst", OP_L, 1'b1, 1'b0, E_ZERO);
    step("fetch after rst", OP_L, 1'b1, 1'b0, E_FETCH);

`ifdef MIPS_CTRL_PERF_EN
    rst = 1'b1;
    step("perf rst", OP_AI, 1'b1, 1'b0, E_ZERO);
    rst = 1'b0;
    step("perf idle", OP_AI, 1'b1, 1'b0, E_ZERO);
    check("perf cycle_cnt start", cycle_cnt, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step("perf addi fetch",  OP_AI, 1'b1, 1'b0, E_FETCH);
      step("perf addi decode", OP_AI, 1'b1, 1'b0, E_DECODE);
      step("perf addi exec",   OP_AI, 1'b1, 1'b0, E_ADDI_EXEC);
      step("perf addi wb",     OP_AI, 1'b1, 1'b0, E_ADDI_WB);
    end
    step("perf j fetch",  OP_JMP, 1'b1, 1'b0, E_FETCH);
    step("perf j decode", OP_JMP, 1'b1, 1'b0, E_DECODE);
    step("perf j jump",   OP_JMP, 1'b1, 1'b0, E_JUMP);
    check("perf cycle_cnt", cycle_cnt, 32'd11);
    check("perf instret_cnt", instret_cnt, 32'd3);
    step("perf fetch", OP_JMP, 1'b1, 1'b0, E_FETCH);
`endif

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) check("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
